// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt priority unit.
// Priority rank 0 is the highest level, which sits one step above the lowest-priority pointer.
package pic_pkg;
    localparam int NUM_IRQ = 8;
    localparam logic [2:0] LP_RESET = 3'd7;

    typedef enum logic {
        ACK_IDLE  = 1'b0,
        ACK_FIRST = 1'b1
    } ack_state_t;

    function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] lp);
        return idx - lp - 3'd1;
    endfunction

    function automatic logic [NUM_IRQ-1:0] lvl_onehot(input logic [2:0] lvl);
        return {{(NUM_IRQ-1){1'b0}}, 1'b1} << lvl;
    endfunction
endpackage

// File: rtl/irq_priority_unit_prio_pick.sv
// Combinational rotating priority picker.
// Rotates the request vector so the highest level lands at bit 0, finds the first set bit, and maps it back.
module prio_pick
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    input  logic [2:0]         lp,
    output logic [2:0]         idx,
    output logic               valid
);
    logic [NUM_IRQ-1:0] rot;
    logic [2:0]         first;

    always_comb begin
        for (int k = 0; k < NUM_IRQ; k++) begin
            rot[k] = req[lp + 3'd1 + 3'(k)];
        end
        first = '0;
        // Scan downward so the lowest set position (highest priority) is the last one written.
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (rot[k]) first = 3'(k);
        end
        valid = |rot;
        idx   = lp + 3'd1 + first;
    end
endmodule

// File: rtl/irq_priority_unit.sv
// 8259-style interrupt priority unit: request capture, masking, rotating priority, INTA handshake, EOI handling.
// INTA is active low; an acknowledge event is a sampled 1->0 transition. The first event freezes the winner, the second closes the cycle.
module irq_priority_unit
    import pic_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_IRQ-1:0]  IR,
    input  logic                LTIM,
    input  logic                INTA,
    input  logic                IMR_WR,
    input  logic [NUM_IRQ-1:0]  IMR_DATA,
    input  logic                EOI,
    input  logic                SEOI,
    input  logic [2:0]          SEOI_LEVEL,
    input  logic                AEOI,
    input  logic                ROTATE,
    output logic                INT,
    output logic [NUM_IRQ-1:0]  ISR,
    output logic [NUM_IRQ-1:0]  IRR,
    output logic [NUM_IRQ-1:0]  IMR,
    output ack_state_t          dbg_state,
    output logic [2:0]          dbg_lp
);
    ack_state_t         state, state_next;
    logic [NUM_IRQ-1:0] ir_q;
    logic               inta_q;
    logic [2:0]         lp;
    logic [2:0]         w_q;

    logic               inta_fall, first_edge, second_edge;
    logic [2:0]         top_idx, post_idx, win_idx;
    logic               top_vld, post_vld, win_vld;
    logic [NUM_IRQ-1:0] elig_now, elig_post, eoi_clr, isr_post;
    logic [NUM_IRQ-1:0] isr_next, irr_next;
    logic [2:0]         lp_next, ack_lvl;

    assign inta_fall = inta_q & ~INTA;
    assign dbg_state = state;
    assign dbg_lp    = lp;

    prio_pick u_pick_isr  (.req(ISR),       .lp(lp), .idx(top_idx),  .valid(top_vld));
    prio_pick u_pick_post (.req(isr_post),  .lp(lp), .idx(post_idx), .valid(post_vld));
    prio_pick u_pick_win  (.req(elig_post), .lp(lp), .idx(win_idx),  .valid(win_vld));

    always_ff @(posedge CLK) begin
        if (RST) state <= ACK_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (inta_fall) state_next = (state == ACK_IDLE) ? ACK_FIRST : ACK_IDLE;
    end

    always_comb begin
        first_edge  = inta_fall && (state == ACK_IDLE);
        second_edge = inta_fall && (state == ACK_FIRST);
    end

    always_comb begin
        // SEOI wins over a same-cycle EOI; the winner is chosen against the ISR left after either clear.
        eoi_clr = '0;
        if (SEOI)                eoi_clr = lvl_onehot(SEOI_LEVEL);
        else if (EOI && top_vld) eoi_clr = lvl_onehot(top_idx);
        isr_post = ISR & ~eoi_clr;

        for (int i = 0; i < NUM_IRQ; i++) begin
            elig_now[i]  = IRR[i] && !IMR[i] &&
                           (!top_vld || (prio_rank(3'(i), lp) < prio_rank(top_idx, lp)));
            elig_post[i] = IRR[i] && !IMR[i] &&
                           (!post_vld || (prio_rank(3'(i), lp) < prio_rank(post_idx, lp)));
        end

        ack_lvl  = win_vld ? win_idx : 3'd7;
        isr_next = isr_post;
        irr_next = LTIM ? IR : (IRR | (IR & ~ir_q));
        if (first_edge) begin
            isr_next = isr_next | lvl_onehot(ack_lvl);
            if (win_vld) irr_next = irr_next & ~lvl_onehot(win_idx);
        end
        if (second_edge && AEOI) isr_next = isr_next & ~lvl_onehot(w_q);

        lp_next = lp;
        if (ROTATE && SEOI)                 lp_next = SEOI_LEVEL;
        else if (ROTATE && EOI && top_vld)  lp_next = top_idx;
        if (ROTATE && second_edge && AEOI)  lp_next = w_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_q   <= '0;
            inta_q <= 1'b1;
            IRR    <= '0;
            ISR    <= '0;
            IMR    <= '0;
            lp     <= LP_RESET;
            w_q    <= '0;
            INT    <= 1'b0;
        end else begin
            ir_q   <= IR;
            inta_q <= INTA;
            IRR    <= irr_next;
            ISR    <= isr_next;
            lp     <= lp_next;
            INT    <= (|elig_now) && !first_edge;
            if (IMR_WR)     IMR <= IMR_DATA;
            if (first_edge) w_q <= ack_lvl;
        end
    end
endmodule

// File: tb/tb_irq_priority_unit.sv
// Directed-vector bench for irq_priority_unit with hand-computed expectations.
module tb_irq_priority_unit;
    import pic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ir;
    logic       ltim, inta, imr_wr, eoi, seoi, aeoi, rotate;
    logic [7:0] imr_data;
    logic [2:0] seoi_level;
    logic       int_o;
    logic [7:0] isr, irr, imr;
    ack_state_t dbg_state;
    logic [2:0] dbg_lp;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    irq_priority_unit dut (
        .CLK(clk), .RST(rst), .IR(ir), .LTIM(ltim), .INTA(inta),
        .IMR_WR(imr_wr), .IMR_DATA(imr_data), .EOI(eoi), .SEOI(seoi),
        .SEOI_LEVEL(seoi_level), .AEOI(aeoi), .ROTATE(rotate),
        .INT(int_o), .ISR(isr), .IRR(irr), .IMR(imr),
        .dbg_state(dbg_state), .dbg_lp(dbg_lp)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ir_pulse(input logic [7:0] v);
        ir = v;
        tick();
        ir = 8'h00;
        tick();
    endtask

    task automatic ack();
        inta = 1'b0; tick();
        inta = 1'b1; tick();
        inta = 1'b0; tick();
        inta = 1'b1; tick();
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1; tick();
        eoi = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        ir = '0; ltim = 0; inta = 1; imr_wr = 0; imr_data = '0;
        eoi = 0; seoi = 0; seoi_level = '0; aeoi = 0; rotate = 0;
        do_reset();
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_imr", imr, 8'h00);
        chk("rst_int", 8'(int_o), 8'h00);
        chk("rst_lp", 8'(dbg_lp), 8'h07);
        chk("rst_state", 8'(dbg_state), 8'(ACK_IDLE));

        // Single edge-triggered request through a full acknowledge and EOI.
        ir = 8'h08; tick(); ir = 8'h00;
        chk("t1_irr", irr, 8'h08);
        chk("t1_int_lat", 8'(int_o), 8'h00);
        tick();
        chk("t1_int", 8'(int_o), 8'h01);
        inta = 1'b0; tick();
        chk("t1_isr_first", isr, 8'h08);
        chk("t1_irr_first", irr, 8'h00);
        chk("t1_int_first", 8'(int_o), 8'h00);
        chk("t1_state_first", 8'(dbg_state), 8'(ACK_FIRST));
        inta = 1'b1; tick(); inta = 1'b0; tick(); inta = 1'b1; tick();
        chk("t1_state_second", 8'(dbg_state), 8'(ACK_IDLE));
        eoi_pulse();
        chk("t1_isr_eoi", isr, 8'h00);

        // Two simultaneous requests: fixed priority serves IR2 then IR5.
        ir_pulse(8'h24);
        chk("t2_irr", irr, 8'h24);
        ack();
        chk("t2_isr_a", isr, 8'h04);
        chk("t2_irr_a", irr, 8'h20);
        chk("t2_int_blocked", 8'(int_o), 8'h00);
        eoi_pulse(); tick();
        chk("t2_int_again", 8'(int_o), 8'h01);
        ack();
        chk("t2_isr_b", isr, 8'h20);

        // Nesting: IR6 blocked by IR5 in service, IR1 preempts.
        ir_pulse(8'h40); tick();
        chk("t3_irr6", irr, 8'h40);
        chk("t3_int6", 8'(int_o), 8'h00);
        ir_pulse(8'h02);
        chk("t3_int1", 8'(int_o), 8'h01);
        ack();
        chk("t3_isr_nest", isr, 8'h22);
        chk("t3_irr_nest", irr, 8'h40);
        eoi_pulse();
        chk("t3_eoi_top", isr, 8'h20);
        eoi_pulse(); tick();
        ack();
        chk("t3_isr6", isr, 8'h40);
        eoi_pulse();
        chk("t3_isr_clr", isr, 8'h00);

        // Rotation on EOI and SEOI.
        rotate = 1'b1;
        ir_pulse(8'h10); ack();
        eoi_pulse();
        chk("t4_lp_eoi", 8'(dbg_lp), 8'h04);
        chk("t4_isr_eoi", isr, 8'h00);
        ir_pulse(8'h28); ack();
        chk("t4_isr_rot", isr, 8'h20);
        chk("t4_irr_rot", irr, 8'h08);
        seoi = 1'b1; seoi_level = 3'd5; tick(); seoi = 1'b0;
        chk("t4_isr_seoi", isr, 8'h00);
        chk("t4_lp_seoi", 8'(dbg_lp), 8'h05);
        tick(); ack();
        chk("t4_isr3", isr, 8'h08);
        eoi_pulse();
        chk("t4_lp3", 8'(dbg_lp), 8'h03);
        rotate = 1'b0;

        // Spurious acknowledge, then reset mid-sequence.
        inta = 1'b0; tick();
        chk("t5_spur_isr", isr, 8'h80);
        chk("t5_spur_irr", irr, 8'h00);
        inta = 1'b1; tick();
        do_reset();
        chk("t5_rst_state", 8'(dbg_state), 8'(ACK_IDLE));
        chk("t5_rst_lp", 8'(dbg_lp), 8'h07);
        chk("t5_rst_isr", isr, 8'h00);
        inta = 1'b0; tick();
        chk("t5_first_again", 8'(dbg_state), 8'(ACK_FIRST));
        inta = 1'b1; tick(); inta = 1'b0; tick(); inta = 1'b1; tick();
        do_reset();

        // Auto-EOI.
        aeoi = 1'b1;
        ir_pulse(8'h01);
        inta = 1'b0; tick();
        chk("t6_aeoi_first", isr, 8'h01);
        inta = 1'b1; tick(); inta = 1'b0; tick();
        chk("t6_aeoi_second", isr, 8'h00);
        chk("t6_state", 8'(dbg_state), 8'(ACK_IDLE));
        inta = 1'b1; tick();
        aeoi = 1'b0;

        // Level mode with masking.
        ltim = 1'b1;
        imr_wr = 1'b1; imr_data = 8'hFF; tick(); imr_wr = 1'b0;
        chk("t7_imr", imr, 8'hFF);
        ir = 8'h04; tick(); tick();
        chk("t7_irr_masked", irr, 8'h04);
        chk("t7_int_masked", 8'(int_o), 8'h00);
        imr_wr = 1'b1; imr_data = 8'h00; tick(); imr_wr = 1'b0;
        tick();
        chk("t7_int_unmask", 8'(int_o), 8'h01);
        ir = 8'h00; tick();
        chk("t7_irr_level_drop", irr, 8'h00);
        ltim = 1'b0; tick();

        // Same-cycle SEOI+EOI, then same-cycle first INTA edge with EOI.
        ir_pulse(8'h20); ack();
        ir_pulse(8'h02); ack();
        chk("t8_isr_two", isr, 8'h22);
        eoi = 1'b1; seoi = 1'b1; seoi_level = 3'd5; tick();
        eoi = 1'b0; seoi = 1'b0;
        chk("t8_seoi_wins", isr, 8'h02);
        ir_pulse(8'h08);
        chk("t8_int_blocked", 8'(int_o), 8'h00);
        inta = 1'b0; eoi = 1'b1; tick(); eoi = 1'b0;
        chk("t8_isr_post_eoi", isr, 8'h08);
        chk("t8_irr_post_eoi", irr, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0; tick(); inta = 1'b1; tick();
        eoi_pulse();
        chk("t8_isr_final", isr, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/irq_priority_unit.md
IRQ_PRIORITY_UNIT -- requirements
Module: irq_priority_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: CLK, RST.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 IR  input  8  raw interrupt request lines, IR[0]..IR[7], synchronous to CLK.
REQ-005 LTIM  input  1  trigger mode from ICW1 bit 3: 1 = level, 0 = rising edge.
REQ-006 INTA  input  1  active-low acknowledge strobe, synchronous to CLK; events are its falling edges.
REQ-007 IMR_WR  input  1  one-cycle strobe; load IMR from IMR_DATA.
REQ-008 IMR_DATA  input  8  OCW1 mask value; bit = 1 masks that IR.
REQ-009 EOI  input  1  one-cycle non-specific end-of-interrupt strobe.
REQ-010 SEOI  input  1  one-cycle specific end-of-interrupt strobe.
REQ-011 SEOI_LEVEL  input  3  IR level cleared by SEOI.
REQ-012 AEOI  input  1  auto-EOI mode from ICW4 bit 1.
REQ-013 ROTATE  input  1  rotate-on-EOI mode; applies to EOI, SEOI and auto-EOI.
REQ-014 INT  output  1  registered interrupt request to CPU.
REQ-015 ISR  output  8  in-service register; consumed by the vector-address logic.
REQ-016 IRR  output  8  interrupt request register.
REQ-017 IMR  output  8  interrupt mask register.

Function
REQ-018 Edge mode (LTIM=0): IRR[i] SHALL set on the cycle after IR[i] is sampled 1 while its previous sample was 0.
REQ-019 Level mode (LTIM=1): IRR[i] SHALL equal the registered IR[i] unless cleared by acknowledge in that cycle.
REQ-020 A 3-bit lowest-priority pointer LP SHALL define priority; highest = (LP+1) mod 8, descending cyclically.
REQ-021 A request i is eligible when IRR[i]=1, IMR[i]=0, and i is strictly higher priority than every set ISR bit.
REQ-022 INT SHALL assert one cycle after any request becomes eligible; it deasserts one cycle after the first INTA falling edge or after eligibility is lost.
REQ-023 Acknowledge FSM states: ACK_IDLE, ACK_FIRST; ACK_IDLE -> ACK_FIRST on INTA falling edge; ACK_FIRST -> ACK_IDLE on the next INTA falling edge.
REQ-024 First INTA falling edge: the winner w SHALL be frozen, ISR[w] set and IRR[w] cleared in the same cycle.
REQ-025 First INTA falling edge with no eligible request: ISR[7] SHALL set (spurious IR7); IRR unchanged.
REQ-026 Second INTA falling edge with AEOI=1: the ISR bit set at the first edge SHALL clear; with ROTATE=1, LP becomes that level.
REQ-027 EOI: the highest-priority set ISR bit SHALL clear; with ROTATE=1, LP becomes that level; no effect if ISR=0.
REQ-028 SEOI: ISR[SEOI_LEVEL] SHALL clear; with ROTATE=1, LP = SEOI_LEVEL.
REQ-029 Same-cycle first INTA edge and EOI/SEOI: the EOI clear SHALL apply first; the winner is then chosen against the post-EOI ISR.
REQ-030 Same-cycle EOI and SEOI: SEOI SHALL take precedence; EOI is ignored.
REQ-031 IMR_WR SHALL take effect in the next cycle; masking never clears IRR or ISR bits.
REQ-032 A request arriving during ACK_FIRST SHALL set IRR but SHALL NOT alter the frozen winner.

Reset
REQ-033 On RST: IRR=0, ISR=0, IMR=0x00, LP=7, INT=0, FSM=ACK_IDLE, IR history=0.
REQ-034 RST mid-acknowledge SHALL abandon the sequence; the next INTA falling edge counts as the first.

Structure
REQ-035 Package pic_pkg SHALL hold NUM_IRQ=8, LP_RESET=3'd7, and the ACK_IDLE/ACK_FIRST state type.
REQ-036 One sub-module, prio_pick, SHALL be purely combinational: rotate by LP, find-first, unrotate, output the index and a valid flag.

Verification
REQ-037 Reset, IMR=0x00, edge mode, pulse IR[3] -> IRR=0x08, INT=1 next cycle; first INTA edge -> ISR=0x08, IRR=0x00; EOI -> ISR=0x00.
REQ-038 IR[5] and IR[2] together -> first INTA edge sets ISR=0x04; EOI; second acknowledge sets ISR=0x20.
REQ-039 ISR=0x20 in service, raise IR[6] -> INT stays 0; raise IR[1] -> INT=1 (nesting).
REQ-040 ROTATE=1, service IR[4], EOI -> LP=4; IR[3] and IR[5] together -> IR[5] wins.
REQ-041 AEOI=1, IR[0] acknowledged -> ISR=0x01 after first edge, 0x00 after second edge.
REQ-042 First INTA edge with IRR=0 -> ISR=0x80; IMR_WR 0xFF with IR[2] high in level mode -> INT=0, IRR[2]=1.
